// File: rtl/xm_mem_responder.sv
// ---------------------------------------------------------------------------
// xm_mem_responder
//
// Memory-side responder for the XM multi-cycle CPU. It accepts one request
// at a time from the control plane, runs a single-port synchronous SRAM
// access with WAIT_STATES extra cycles, steers byte lanes little-endian and
// returns registered read data to the datapath.
//
// Handshake (control plane <-> responder):
//   The controller raises memEn_i together with memRW_i/byteOp_i/addr_i/
//   wrData_i and keeps them stable while memBusy_o is high. memBusy_o
//   follows memEn_i combinationally in IDLE, so busy is visible in the
//   request cycle itself. The request is accepted at the first rising edge
//   where memEn_i is high in IDLE. memBusy_o stays high through ACCESS and
//   falls in DONE, where rdData_o is already valid for reads; memEn_i is
//   ignored in DONE and the controller drops it (or issues the next
//   request) in the cycle after.
//
// Ports:
//   clk_i        clock, rising edge
//   arst_i       asynchronous reset, active-high
//   memEn_i      request strobe
//   memRW_i      0 = read, 1 = write
//   byteOp_i     1 = byte access, 0 = word access
//   addr_i       byte address
//   wrData_i     write data (byte writes use [7:0])
//   rdData_o     registered read data
//   memBusy_o    high while a request is in service
//   alignErr_o   one-cycle pulse in DONE for a word access to an odd address
//   sramCe_o     SRAM chip enable
//   sramWe_o     SRAM write enable
//   sramBe_o     SRAM byte enables, [0] low lane, [1] high lane
//   sramAddr_o   SRAM word address
//   sramWdata_o  SRAM write data
//   sramRdata_i  SRAM read data, valid during the last ACCESS cycle
//   dbgState_o   current FSM state (IDLE=0, ACCESS=1, DONE=2)
// ---------------------------------------------------------------------------
module xm_mem_responder #(
    parameter int WORD        = 16,
    parameter int ADDR_W      = 15,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              memEn_i,
    input  logic              memRW_i,
    input  logic              byteOp_i,
    input  logic [WORD-1:0]   addr_i,
    input  logic [WORD-1:0]   wrData_i,
    output logic [WORD-1:0]   rdData_o,
    output logic              memBusy_o,
    output logic              alignErr_o,
    output logic              sramCe_o,
    output logic              sramWe_o,
    output logic [1:0]        sramBe_o,
    output logic [ADDR_W-1:0] sramAddr_o,
    output logic [WORD-1:0]   sramWdata_o,
    input  logic [WORD-1:0]   sramRdata_i,
    output logic [1:0]        dbgState_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t          state;
    state_t          stateNext;
    logic [3:0]      waitCnt;
    logic [3:0]      waitCntNext;

    // Request captured at acceptance; the controller may change its
    // inputs freely once the access is under way.
    logic            reqRW;
    logic            reqByte;
    logic [WORD-1:0] reqAddr;
    logic [WORD-1:0] reqWdata;

    logic            accept;
    logic            lastAccess;
    logic [WORD-1:0] rdSteered;

    // -----------------------------------------------------------------------
    // State, counter, request latch and read-data register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= IDLE;
            waitCnt  <= '0;
            reqRW    <= 1'b0;
            reqByte  <= 1'b0;
            reqAddr  <= '0;
            reqWdata <= '0;
            rdData_o <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (accept) begin
                reqRW    <= memRW_i;
                reqByte  <= byteOp_i;
                reqAddr  <= addr_i;
                reqWdata <= wrData_i;
            end
            // Writes leave the last read value in place.
            if (lastAccess && !reqRW) begin
                rdData_o <= rdSteered;
            end
        end
    end

    // Byte reads return the addressed lane zero-extended; sign extension
    // is the datapath's job.
    always_comb begin
        rdSteered = sramRdata_i;
        if (reqByte) begin
            rdSteered = {8'h00, (reqAddr[0] ? sramRdata_i[15:8] : sramRdata_i[7:0])};
        end
    end

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        accept      = 1'b0;
        lastAccess  = 1'b0;
        memBusy_o   = 1'b0;
        alignErr_o  = 1'b0;
        sramCe_o    = 1'b0;
        sramWe_o    = 1'b0;
        sramBe_o    = 2'b00;
        sramAddr_o  = '0;
        sramWdata_o = '0;

        case (state)
            IDLE: begin
                memBusy_o = memEn_i;
                if (memEn_i) begin
                    accept      = 1'b1;
                    waitCntNext = WAIT_INIT;
                    stateNext   = ACCESS;
                end
            end

            ACCESS: begin
                memBusy_o  = 1'b1;
                sramCe_o   = 1'b1;
                sramWe_o   = reqRW;
                // addr[0] is dropped, so a misaligned word hits the
                // aligned word that contains it.
                sramAddr_o = reqAddr[ADDR_W:1];
                if (reqByte) begin
                    sramBe_o    = reqAddr[0] ? 2'b10 : 2'b01;
                    sramWdata_o = {reqWdata[7:0], reqWdata[7:0]};
                end else begin
                    sramBe_o    = 2'b11;
                    sramWdata_o = reqWdata;
                end
                if (waitCnt == 4'd0) begin
                    lastAccess = 1'b1;
                    stateNext  = DONE;
                end else begin
                    waitCntNext = waitCnt - 4'd1;
                end
            end

            DONE: begin
                // memEn_i is deliberately not looked at here.
                alignErr_o = !reqByte && reqAddr[0];
                stateNext  = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign dbgState_o = state;

endmodule

// File: tb/tb_xm_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_xm_mem_responder
//
// Three responders share one clock and reset: instance 0 with 1 wait state,
// instance 1 with 3, instance 2 with 0. Each has its own behavioural SRAM.
// ---------------------------------------------------------------------------
module tb_xm_mem_responder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic arst;

    // ---------------- DUT signals ----------------
    logic        memEn[3];
    logic        memRW[3];
    logic        byteOp[3];
    logic [15:0] addr[3];
    logic [15:0] wrData[3];
    logic [15:0] rdData[3];
    logic        memBusy[3];
    logic        alignErr[3];
    logic        sramCe[3];
    logic        sramWe[3];
    logic [1:0]  sramBe[3];
    logic [14:0] sramAddr[3];
    logic [15:0] sramWdata[3];
    logic [15:0] sramRdata[3];
    logic [1:0]  dbgState[3];

    // ---------------- SRAM environment model ----------------
    logic [15:0] sramMem[3][1024];
    logic        clrMem;
    logic        plEn;
    int          plK;
    int          plIdx;
    logic [15:0] plData;

    always @(posedge clk) begin
        if (clrMem) begin
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < 1024; i++)
                    sramMem[k][i] <= 16'h0000;
        end else if (plEn) begin
            sramMem[plK][plIdx] <= plData;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (sramCe[k] && sramWe[k]) begin
                    if (sramBe[k][0]) sramMem[k][sramAddr[k][9:0]][7:0]  <= sramWdata[k][7:0];
                    if (sramBe[k][1]) sramMem[k][sramAddr[k][9:0]][15:8] <= sramWdata[k][15:8];
                end
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : gDut
        xm_mem_responder #(
            .WORD(16),
            .ADDR_W(15),
            .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .clk_i      (clk),
            .arst_i     (arst),
            .memEn_i    (memEn[g]),
            .memRW_i    (memRW[g]),
            .byteOp_i   (byteOp[g]),
            .addr_i     (addr[g]),
            .wrData_i   (wrData[g]),
            .rdData_o   (rdData[g]),
            .memBusy_o  (memBusy[g]),
            .alignErr_o (alignErr[g]),
            .sramCe_o   (sramCe[g]),
            .sramWe_o   (sramWe[g]),
            .sramBe_o   (sramBe[g]),
            .sramAddr_o (sramAddr[g]),
            .sramWdata_o(sramWdata[g]),
            .sramRdata_i(sramRdata[g]),
            .dbgState_o (dbgState[g])
        );
        assign sramRdata[g] = sramMem[g][sramAddr[g][9:0]];
    end

    // ---------------- scoreboard state ----------------
    int          nChk  = 0;
    int          nFail = 0;
    logic [15:0] refMem[3][1024];
    logic [15:0] lastRd[3];

    function automatic int wsOf(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: word-addressed memory, little-endian lanes,
    // computed with plain arithmetic on the byte address.
    task automatic model(input int k, input bit rw, input bit bop,
                         input logic [15:0] a, input logic [15:0] wd,
                         output logic [15:0] eRd, output logic [1:0] eBe,
                         output logic [15:0] eWd, output logic [14:0] eSa,
                         output bit eAl);
        int wa  = int'(a) / 2;
        int idx = wa % 1024;
        int hi  = int'(a) % 2;
        int old = int'(refMem[k][idx]);
        int lo8 = int'(wd) % 256;
        eSa = 15'(wa);
        eAl = !bop && (hi == 1);
        if (bop) begin
            eBe = (hi == 1) ? 2'b10 : 2'b01;
            eWd = 16'(lo8 * 257);
        end else begin
            eBe = 2'b11;
            eWd = wd;
        end
        if (rw) begin
            if (bop)
                refMem[k][idx] = (hi == 1) ? 16'((old % 256) + lo8 * 256)
                                           : 16'((old / 256) * 256 + lo8);
            else
                refMem[k][idx] = wd;
            eRd = lastRd[k];
        end else begin
            eRd = bop ? 16'((hi == 1) ? old / 256 : old % 256) : 16'(old);
            lastRd[k] = eRd;
        end
    endtask

    // ---------------- driver tasks ----------------
    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic preload(input int k, input int idx, input logic [15:0] d);
        plEn = 1'b1; plK = k; plIdx = idx; plData = d;
        refMem[k][idx] = d;
        @(posedge clk); #1;
        plEn = 1'b0;
    endtask

    task automatic txn(input int k, input bit rw, input bit bop,
                       input logic [15:0] a, input logic [15:0] wd, input bit hold,
                       input logic [15:0] eRd, input logic [1:0] eBe,
                       input logic [15:0] eWd, input logic [14:0] eSa, input bit eAl);
        string t = $sformatf("i%0d a=%h rw=%0d b=%0d", k, a, rw, bop);
        memEn[k] = 1'b1; memRW[k] = rw; byteOp[k] = bop; addr[k] = a; wrData[k] = wd;
        @(negedge clk);
        chk({t, " req_busy"}, 32'(memBusy[k]), 1);
        chk({t, " req_ce"}, 32'(sramCe[k]), 0);
        for (int i = 0; i <= wsOf(k); i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("%s acc%0d_busy", t, i), 32'(memBusy[k]), 1);
            chk($sformatf("%s acc%0d_ce", t, i), 32'(sramCe[k]), 1);
            chk($sformatf("%s acc%0d_we", t, i), 32'(sramWe[k]), 32'(rw));
            chk($sformatf("%s acc%0d_addr", t, i), 32'(sramAddr[k]), 32'(eSa));
            chk($sformatf("%s acc%0d_be", t, i), 32'(sramBe[k]), 32'(eBe));
            chk($sformatf("%s acc%0d_wdata", t, i), 32'(sramWdata[k]), 32'(eWd));
            chk($sformatf("%s acc%0d_align", t, i), 32'(alignErr[k]), 0);
        end
        @(posedge clk); @(negedge clk);
        chk({t, " done_busy"}, 32'(memBusy[k]), 0);
        chk({t, " done_ce"}, 32'(sramCe[k]), 0);
        chk({t, " done_we"}, 32'(sramWe[k]), 0);
        chk({t, " done_be"}, 32'(sramBe[k]), 0);
        chk({t, " done_wdata"}, 32'(sramWdata[k]), 0);
        chk({t, " done_align"}, 32'(alignErr[k]), 32'(eAl));
        chk({t, " done_rd"}, 32'(rdData[k]), 32'(eRd));
        @(posedge clk); #1;
        if (!hold) memEn[k] = 1'b0;
    endtask

    task automatic checkQuiet(input int k, input string tag);
        chk($sformatf("%s i%0d busy", tag, k), 32'(memBusy[k]), 0);
        chk($sformatf("%s i%0d align", tag, k), 32'(alignErr[k]), 0);
        chk($sformatf("%s i%0d ce", tag, k), 32'(sramCe[k]), 0);
        chk($sformatf("%s i%0d we", tag, k), 32'(sramWe[k]), 0);
        chk($sformatf("%s i%0d be", tag, k), 32'(sramBe[k]), 0);
        chk($sformatf("%s i%0d addr", tag, k), 32'(sramAddr[k]), 0);
        chk($sformatf("%s i%0d wdata", tag, k), 32'(sramWdata[k]), 0);
    endtask

    task automatic modelTxn(input int k, input bit rw, input bit bop,
                            input logic [15:0] a, input logic [15:0] wd, input bit hold);
        logic [15:0] eRd, eWd;
        logic [1:0]  eBe;
        logic [14:0] eSa;
        bit          eAl;
        model(k, rw, bop, a, wd, eRd, eBe, eWd, eSa, eAl);
        txn(k, rw, bop, a, wd, hold, eRd, eBe, eWd, eSa, eAl);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          rw;
        bit          bop;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] eRd;
        logic [1:0]  eBe;
        logic [15:0] eWd;
        logic [14:0] eSa;
        bit          eAl;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [15:0] dRd, dWd;
        logic [1:0]  dBe;
        logic [14:0] dSa;
        bit          dAl;

        // rw  bop  addr      wdata     expRd     be     expWdata  sramAddr  align
        tbl[0] = '{0, 0, 16'h0020, 16'h0000, 16'h1234, 2'b11, 16'h0000, 15'h0010, 0};
        tbl[1] = '{1, 0, 16'h0020, 16'hBEEF, 16'h1234, 2'b11, 16'hBEEF, 15'h0010, 0};
        tbl[2] = '{0, 1, 16'h0021, 16'h0000, 16'h00BE, 2'b10, 16'h0000, 15'h0010, 0};
        tbl[3] = '{0, 1, 16'h0020, 16'h0077, 16'h00EF, 2'b01, 16'h7777, 15'h0010, 0};
        tbl[4] = '{1, 1, 16'h0041, 16'h00AB, 16'h00EF, 2'b10, 16'hABAB, 15'h0020, 0};
        tbl[5] = '{0, 0, 16'h0040, 16'h0000, 16'hAB11, 2'b11, 16'h0000, 15'h0020, 0};
        tbl[6] = '{0, 0, 16'h0033, 16'h0000, 16'hCAFE, 2'b11, 16'h0000, 15'h0019, 1};
        tbl[7] = '{0, 0, 16'hFFFE, 16'h0000, 16'h5A5A, 2'b11, 16'h0000, 15'h7FFF, 0};

        arst = 1'b1; clrMem = 1'b1; plEn = 1'b0; plK = 0; plIdx = 0; plData = '0;
        for (int k = 0; k < 3; k++) begin
            memEn[k] = 0; memRW[k] = 0; byteOp[k] = 0; addr[k] = '0; wrData[k] = '0;
            lastRd[k] = '0;
            for (int i = 0; i < 1024; i++) refMem[k][i] = '0;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            checkQuiet(k, "reset");
            chk($sformatf("reset i%0d rd", k), 32'(rdData[k]), 0);
        end
        repeat (2) @(posedge clk);
        #1; clrMem = 1'b0; arst = 1'b0;
        @(posedge clk); #1;

        preload(0, 16'h0010, 16'h1234);
        preload(0, 16'h0020, 16'h1111);
        preload(0, 16'h0019, 16'hCAFE);
        preload(0, 16'h03FF, 16'h5A5A);

        // Table on the 1-wait-state instance.
        for (int v = 0; v < 8; v++) begin
            model(0, tbl[v].rw, tbl[v].bop, tbl[v].a, tbl[v].wd, dRd, dBe, dWd, dSa, dAl);
            txn(0, tbl[v].rw, tbl[v].bop, tbl[v].a, tbl[v].wd, 0,
                tbl[v].eRd, tbl[v].eBe, tbl[v].eWd, tbl[v].eSa, tbl[v].eAl);
        end
        @(negedge clk);
        checkQuiet(0, "post_table");
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        for (int k = 0; k < 3; k += 2) begin
            for (int n = 0; n < 30; n++) begin
                bit hold = ($urandom_range(0, 3) == 0) && (n != 29);
                modelTxn(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         16'($urandom_range(0, 127)), 16'($urandom), hold);
                if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end

        // Reset in the second ACCESS cycle of a write (3 wait states).
        preload(1, 16'h0020, 16'h2468);
        modelTxn(1, 0, 0, 16'h0040, 16'h0000, 0);
        memEn[1] = 1; memRW[1] = 1; byteOp[1] = 0; addr[1] = 16'h0100; wrData[1] = 16'h1357;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre ce", 32'(sramCe[1]), 1);
        arst = 1'b1; memEn[1] = 1'b0;
        #1;
        chk("rst_mid ce", 32'(sramCe[1]), 0);
        chk("rst_mid we", 32'(sramWe[1]), 0);
        chk("rst_mid busy", 32'(memBusy[1]), 0);
        chk("rst_mid rd", 32'(rdData[1]), 0);
        chk("rst_mid i0 rd", 32'(rdData[0]), 0);
        for (int k = 0; k < 3; k++) lastRd[k] = '0;
        @(negedge clk); arst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkQuiet(1, "post_rst");
        @(posedge clk); #1;
        modelTxn(1, 0, 0, 16'h0040, 16'h0000, 0);
        modelTxn(1, 1, 1, 16'h0041, 16'h00C3, 0);
        modelTxn(1, 0, 0, 16'h0040, 16'h0000, 0);

        // Zero wait states, three back-to-back reads with memEn held.
        preload(2, 16'h0030, 16'hA1B2);
        preload(2, 16'h0031, 16'hC3D4);
        preload(2, 16'h0032, 16'hE5F6);
        modelTxn(2, 0, 0, 16'h0060, 16'h0000, 1);
        modelTxn(2, 0, 1, 16'h0063, 16'h0000, 1);
        modelTxn(2, 0, 0, 16'h0064, 16'h0000, 0);
        @(negedge clk);
        checkQuiet(2, "b2b_idle");
        @(posedge clk); #1;
        @(negedge clk);
        checkQuiet(2, "b2b_idle2");

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule

// File: doc/xm_mem_responder.md
Name: xm_mem_responder

Overview:
- Memory-side responder for the XM multi-cycle CPU's memory handshake.
- Accepts the control plane's memEn/memRW/byteOp requests with address and write data, and holds memBusy high while it services the access.
- Drives a single-port synchronous SRAM with configurable wait states.
- Performs little-endian byte-lane steering for byte and word accesses and returns read data to the datapath.

Parameters:
- WORD, 16, CPU data width in bits; fixed at 16, byte lanes [7:0] and [15:8].
- ADDR_W, 15, SRAM word-address width; SRAM address = addr_i[ADDR_W:1].
- WAIT_STATES, 1, extra SRAM access cycles; legal range 0..15.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- arst_i  in  1  asynchronous reset, active-high.
- memEn_i  in  1  request strobe from control plane.
- memRW_i  in  1  0 = read, 1 = write.
- byteOp_i  in  1  1 = byte access, 0 = word access.
- addr_i  in  WORD  byte address.
- wrData_i  in  WORD  write data; byte writes use [7:0].
- rdData_o  out  WORD  read data, registered.
- memBusy_o  out  1  high while a request is in service.
- alignErr_o  out  1  one-cycle pulse: word access to an odd address.
- sramCe_o  out  1  SRAM chip enable.
- sramWe_o  out  1  SRAM write enable.
- sramBe_o  out  2  byte enables; [0] = low lane, [1] = high lane.
- sramAddr_o  out  ADDR_W  SRAM word address.
- sramWdata_o  out  WORD  SRAM write data.
- sramRdata_i  in  WORD  SRAM read data; valid during the last ACCESS cycle.

Behaviour:
- Reset (async, immediate): state = IDLE, wait counter = 0, latched request = 0.
  - rdData_o = 0, memBusy_o = 0, alignErr_o = 0.
  - sramCe_o = 0, sramWe_o = 0, sramBe_o = 0, sramAddr_o = 0, sramWdata_o = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - memBusy_o = memEn_i (combinational), so the controller sees busy in the request cycle.
  - On memEn_i = 1 at the clock edge: latch memRW_i, byteOp_i, addr_i, wrData_i; load counter = WAIT_STATES; go to ACCESS.
- ACCESS:
  - Outputs: memBusy_o = 1, sramCe_o = 1, sramWe_o = latched RW, sramAddr_o = latched addr[ADDR_W:1].
  - While counter != 0: decrement counter each clock.
  - When counter == 0: at that edge, capture read data (reads only) and go to DONE.
  - Occupancy: ACCESS lasts exactly WAIT_STATES+1 cycles.
- DONE:
  - Outputs: memBusy_o = 0, SRAM strobes = 0.
  - Always returns to IDLE next clock.
  - memEn_i is ignored in DONE; the controller drops it after seeing busy low.
- Request latency: busy high for WAIT_STATES+2 cycles (request cycle plus ACCESS); busy low in DONE.
- Lane steering, word access:
  - sramBe_o = 2'b11; sramWdata_o = wrData.
  - rdData_o = sramRdata_i.
- Lane steering, byte access:
  - sramWdata_o = {wrData[7:0], wrData[7:0]}.
  - sramBe_o = addr[0] ? 2'b10 : 2'b01.
  - Read returns the selected lane zero-extended: rdData_o = {8'h00, lane}. The datapath performs any sign extension.
- Misaligned word (byteOp = 0, addr[0] = 1):
  - Access proceeds to the aligned word with addr[0] ignored.
  - alignErr_o = 1 for exactly the DONE cycle.
- Writes: rdData_o holds its previous value. Reads: sramWe_o = 0 throughout.
- sramBe_o and sramWdata_o hold their latched values during ACCESS; they are 0 in IDLE and DONE.
- Reset mid-ACCESS: strobes drop asynchronously, the partial access is abandoned, and the FSM is in IDLE after reset release.
- Back-to-back requests: minimum spacing is one IDLE cycle after DONE. Request throughput = one per WAIT_STATES+3 cycles.

Test Plan:
- Word read, WAIT_STATES = 1, SRAM word 0x1234 at word addr 0x0010, addr_i = 0x0020:
  - busy high for request cycle + 2 ACCESS cycles.
  - sramAddr_o = 0x0010, sramBe_o = 11.
  - DONE: busy = 0, rdData_o = 0x1234.
- Byte write, addr_i = 0x0041, wrData_i = 0x00AB:
  - sramWe_o = 1, sramBe_o = 10, sramWdata_o = 0xABAB, sramAddr_o = 0x0020.
  - rdData_o unchanged.
- Byte read from odd and even addresses, SRAM word 0xBEEF:
  - addr 0x0021 -> rdData_o = 0x00BE.
  - addr 0x0020 -> rdData_o = 0x00EF.
- Misaligned word read, addr_i = 0x0033, SRAM word at 0x0019 = 0xCAFE:
  - rdData_o = 0xCAFE.
  - alignErr_o high only in the DONE cycle.
- arst_i pulsed in the second ACCESS cycle of a write, WAIT_STATES = 3:
  - sramCe_o/sramWe_o fall immediately; busy = 0, rdData_o = 0.
  - The next request completes normally.
- WAIT_STATES = 0, three back-to-back reads:
  - Each shows busy for 2 cycles, then 1 DONE cycle, then 1 IDLE cycle.
  - A memEn_i held high through DONE triggers no extra access.
